// File: rtl/inst_rom_loader_pkg.sv
// inst_rom_loader_pkg: shared types and constants for the boot-loaded instruction ROM
package inst_rom_loader_pkg;

    localparam int INST_W      = 32;
    localparam int INST_ADDR_W = 32;

    typedef logic [INST_W-1:0]      inst_bus_t;
    typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;

    localparam inst_bus_t NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    // One step of the load checksum: rotate left by one, then fold in the word
    function automatic inst_bus_t cksum_step(input inst_bus_t acc, input inst_bus_t word);
        return {acc[INST_W-2:0], acc[INST_W-1]} ^ word;
    endfunction

endpackage

// File: rtl/inst_rom_loader_mem_array.sv
// inst_mem_array: word storage with one synchronous write port and one combinational read port
module inst_mem_array
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  inst_bus_t             wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output inst_bus_t             rdata_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    inst_bus_t mem_q [DEPTH];

    // Contents survive reset; only the loader ever writes them
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: fetch responder with host boot-load port; optional load checksum under INST_ROM_CHECKSUM_EN
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rom_ce_i,
    input  inst_addr_bus_t        rom_addr_i,
    output inst_bus_t             rom_data_o,
    input  logic                  load_start_i,
    input  logic                  load_valid_i,
    input  inst_bus_t             load_data_i,
    input  logic                  load_last_i,
    output logic                  load_ready_o,
    output logic                  core_rst_n_o,
    output logic [DEPTH_LOG2:0]   load_count_o,
    output logic                  fetch_fault_o
`ifdef INST_ROM_CHECKSUM_EN
    ,
    output inst_bus_t             load_checksum_o
`endif
);

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  fault_q, fault_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  accept;
    logic                  addr_ok;
    logic                  fetch_hit;
    inst_bus_t             rd_data;

    // A word is well-formed when aligned and inside the array's byte range
    assign addr_ok   = (rom_addr_i[1:0] == 2'b00) &&
                       (rom_addr_i[INST_ADDR_W-1:DEPTH_LOG2+2] == '0);
    assign fetch_hit = (state_q == RUN) && rom_ce_i && addr_ok;
    assign rom_data_o = fetch_hit ? rd_data : NOP;

    // Ready is a pure function of state; a coinciding load_start discards the word
    assign load_ready_o = (state_q == LOAD);
    assign accept       = load_valid_i && load_ready_o && !load_start_i;

    assign core_rst_n_o  = core_rst_n_q;
    assign load_count_o  = count_q;
    assign fetch_fault_o = fault_q;

    inst_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (accept),
        .waddr_i (ptr_q),
        .wdata_i (load_data_i),
        .raddr_i (rom_addr_i[DEPTH_LOG2+1:2]),
        .rdata_o (rd_data)
    );

    // Next-state: load_start restarts everything; a last or full-array accept ends the load
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        fault_d = fault_q;
        if (load_start_i) begin
            state_d = LOAD;
            ptr_d   = '0;
            count_d = '0;
            fault_d = 1'b0;
        end else begin
            if (accept) begin
                ptr_d   = ptr_q + DEPTH_LOG2'(1);
                count_d = count_q + (DEPTH_LOG2 + 1)'(1);
                if (load_last_i || (&ptr_q)) state_d = RUN;
            end
            if ((state_q == RUN) && rom_ce_i && !addr_ok) fault_d = 1'b1;
        end
        core_rst_n_d = (state_d == RUN);
    end

    // State, pointer, count, fault and core reset registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            count_q      <= '0;
            fault_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            fault_q      <= fault_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

`ifdef INST_ROM_CHECKSUM_EN
    inst_bus_t cksum_q, cksum_d;

    // Checksum folds every accepted word and restarts with each load
    always_comb begin
        cksum_d = cksum_q;
        if (load_start_i) cksum_d = '0;
        else if (accept) cksum_d = cksum_step(cksum_q, load_data_i);
    end

    // Checksum register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cksum_q <= '0;
        else cksum_q <= cksum_d;
    end

    assign load_checksum_o = cksum_q;
`endif

endmodule
